// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer for a small accumulator CPU: a six-state
// T-state ring plus a terminal HALT state, with free-run and single-step modes.
module control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode,
    output logic       pc_en,
    output logic       pc_inc,
    output logic       mar_load,
    output logic       mem_en,
    output logic       ir_load,
    output logic       ir_en,
    output logic       a_load,
    output logic       a_en,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_en,
    output logic       out_load,
    output logic       halted,
    output logic [2:0] tstate,
    output logic [7:0] instr_count
);

    typedef enum logic [2:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        T3   = 3'd2,
        T4   = 3'd3,
        T5   = 3'd4,
        T6   = 3'd5,
        HALT = 3'd7
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic pc_inc;
        logic mar_load;
        logic mem_en;
        logic ir_load;
        logic ir_en;
        logic a_load;
        logic a_en;
        logic b_load;
        logic alu_sub;
        logic alu_en;
        logic out_load;
    } ctrl_t;

    state_t state;
    logic   step_prev;
    logic   step_rise;
    logic   adv;
    ctrl_t  ctrl;

    // A step edge while run is high still yields a single advance, since adv is an OR.
    assign step_rise = step & ~step_prev;
    assign adv       = run | step_rise;

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= T1;
            step_prev   <= 1'b0;
            instr_count <= 8'h00;
        end else begin
            step_prev <= step;
            if (adv) begin
                case (state)
                    T1:      state <= T2;
                    T2:      state <= T3;
                    T3:      state <= T4;
                    T4:      state <= (opcode == OP_HLT) ? HALT : T5;
                    T5:      state <= T6;
                    T6: begin
                        state <= T1;
                        if (instr_count != 8'hFF)
                            instr_count <= instr_count + 8'h01;
                    end
                    HALT:    state <= HALT;
                    default: state <= T1;
                endcase
            end
        end
    end

    // NOTE: ctrl is cleared at the top of the block so every path assigns it
    // and no latch is inferred for the control strobes.
    always_comb begin
        ctrl = '0;
        if (adv && !rst) begin
            case (state)
                T1: begin
                    ctrl.pc_en    = 1'b1;
                    ctrl.mar_load = 1'b1;
                end
                T2: ctrl.pc_inc = 1'b1;
                T3: begin
                    ctrl.mem_en  = 1'b1;
                    ctrl.ir_load = 1'b1;
                end
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        ctrl.ir_en    = 1'b1;
                        ctrl.mar_load = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        ctrl.a_en     = 1'b1;
                        ctrl.out_load = 1'b1;
                    end
                    ctrl.alu_sub = (opcode == OP_SUB);
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ctrl.mem_en = 1'b1;
                        ctrl.a_load = 1'b1;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ctrl.mem_en = 1'b1;
                        ctrl.b_load = 1'b1;
                    end
                    ctrl.alu_sub = (opcode == OP_SUB);
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ctrl.alu_en = 1'b1;
                        ctrl.a_load = 1'b1;
                    end
                    ctrl.alu_sub = (opcode == OP_SUB);
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign pc_en    = ctrl.pc_en;
    assign pc_inc   = ctrl.pc_inc;
    assign mar_load = ctrl.mar_load;
    assign mem_en   = ctrl.mem_en;
    assign ir_load  = ctrl.ir_load;
    assign ir_en    = ctrl.ir_en;
    assign a_load   = ctrl.a_load;
    assign a_en     = ctrl.a_en;
    assign b_load   = ctrl.b_load;
    assign alu_sub  = ctrl.alu_sub;
    assign alu_en   = ctrl.alu_en;
    assign out_load = ctrl.out_load;

    assign halted = (state == HALT);
    assign tstate = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected cycles go into a scoreboard
// queue as stimulus is driven and are popped and asserted at the sample point.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       step;
    logic [3:0] opcode;
    logic       pc_en, pc_inc, mar_load, mem_en, ir_load, ir_en;
    logic       a_load, a_en, b_load, alu_sub, alu_en, out_load;
    logic       halted;
    logic [2:0] tstate;
    logic [7:0] instr_count;

    control_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
        .pc_en(pc_en), .pc_inc(pc_inc), .mar_load(mar_load), .mem_en(mem_en),
        .ir_load(ir_load), .ir_en(ir_en), .a_load(a_load), .a_en(a_en),
        .b_load(b_load), .alu_sub(alu_sub), .alu_en(alu_en), .out_load(out_load),
        .halted(halted), .tstate(tstate), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] C_PC_EN  = 12'h800;
    localparam logic [11:0] C_PC_INC = 12'h400;
    localparam logic [11:0] C_MAR    = 12'h200;
    localparam logic [11:0] C_MEM    = 12'h100;
    localparam logic [11:0] C_IR_LD  = 12'h080;
    localparam logic [11:0] C_IR_EN  = 12'h040;
    localparam logic [11:0] C_A_LD   = 12'h020;
    localparam logic [11:0] C_A_EN   = 12'h010;
    localparam logic [11:0] C_B_LD   = 12'h008;
    localparam logic [11:0] C_SUB    = 12'h004;
    localparam logic [11:0] C_ALU_EN = 12'h002;
    localparam logic [11:0] C_OUT    = 12'h001;

    typedef struct packed {
        logic [2:0]  t;
        logic [11:0] ctrl;
        logic [7:0]  cnt;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state kept by the bench from the opcode/advance rules.
    logic [2:0] m_t;
    logic [7:0] m_cnt;
    logic       m_prev;

    function automatic logic [11:0] ctrl_of(input logic [2:0] t, input logic [3:0] op);
        case (t)
            3'd0: return C_PC_EN | C_MAR;
            3'd1: return C_PC_INC;
            3'd2: return C_MEM | C_IR_LD;
            3'd3: case (op)
                      4'h0:    return C_IR_EN | C_MAR;
                      4'h1:    return C_IR_EN | C_MAR;
                      4'h2:    return C_IR_EN | C_MAR | C_SUB;
                      4'hE:    return C_A_EN | C_OUT;
                      default: return 12'h000;
                  endcase
            3'd4: case (op)
                      4'h0:    return C_MEM | C_A_LD;
                      4'h1:    return C_MEM | C_B_LD;
                      4'h2:    return C_MEM | C_B_LD | C_SUB;
                      default: return 12'h000;
                  endcase
            3'd5: case (op)
                      4'h1:    return C_ALU_EN | C_A_LD;
                      4'h2:    return C_ALU_EN | C_A_LD | C_SUB;
                      default: return 12'h000;
                  endcase
            default: return 12'h000;
        endcase
    endfunction

    task automatic check(input string tag);
        exp_t o;
        exp_t e;
        o.t    = tstate;
        o.ctrl = {pc_en, pc_inc, mar_load, mem_en, ir_load, ir_en,
                  a_load, a_en, b_load, alu_sub, alu_en, out_load};
        o.cnt  = instr_count;
        o.halt = halted;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed a DUT sample, expected a queued entry (scoreboard empty)", tag);
            return;
        end
        e = sb.pop_front();
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed t=%0d ctrl=%03h cnt=%02h halt=%b, expected t=%0d ctrl=%03h cnt=%02h halt=%b",
                   tag, o.t, o.ctrl, o.cnt, o.halt, e.t, e.ctrl, e.cnt, e.halt);
        end
    endtask

    task automatic push_model(input logic [11:0] c);
        exp_t e;
        e.t    = m_t;
        e.ctrl = c;
        e.cnt  = m_cnt;
        e.halt = (m_t == 3'd7);
        sb.push_back(e);
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, then the
    // rising edge applies the advance to the reference state.
    task automatic tick(input logic r, input logic s, input logic [3:0] op, input string tag);
        logic a;
        @(negedge clk);
        run = r; step = s; opcode = op;
        a = r | (s & ~m_prev);
        push_model((a && m_t != 3'd7) ? ctrl_of(m_t, op) : 12'h000);
        #1 check(tag);
        m_prev = s;
        if (a && m_t != 3'd7) begin
            if (m_t == 3'd3 && op == 4'hF) begin
                m_t = 3'd7;
            end else if (m_t == 3'd5) begin
                m_t = 3'd0;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
            end else begin
                m_t = m_t + 3'd1;
            end
        end
    endtask

    // Asynchronous reset between clock edges; checked before any rising edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        m_t = 3'd0; m_cnt = 8'h00; m_prev = 1'b0;
        push_model(12'h000);
        #1 check(tag);
        run = 1'b0; step = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] prog [4];
        logic [7:0] cnt_snap;
        prog[0] = 8'h0D; prog[1] = 8'h1E; prog[2] = 8'h2F; prog[3] = 8'hF0;

        rst = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'h0;
        m_t = 3'd0; m_cnt = 8'h00; m_prev = 1'b0;
        #3;
        push_model(12'h000);
        check("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Single-step: idle, then a held step level gives exactly one advance.
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 4'h0, "step_idle");
        for (int i = 0; i < 3; i++)  tick(1'b0, 1'b1, 4'h0, "step_held");
        for (int i = 0; i < 2; i++)  tick(1'b0, 1'b0, 4'h0, "step_released");
        assert (tstate === 3'd1) else begin
            n_fail++;
            $error("FAIL step_one_advance: observed tstate=%0d, expected 1", tstate);
        end
        n_checks++;

        // Free-running program; opcode is junk during fetch to show it is ignored.
        pulse_reset("rst_before_prog");
        for (int i = 0; i < 4; i++)
            for (int t = 0; t < 6; t++)
                tick(1'b1, 1'b0, (t < 3) ? 4'($urandom_range(0, 15)) : prog[i][7:4],
                     $sformatf("prog_i%0d_t%0d", i, t + 1));
        n_checks++;
        assert (halted === 1'b1 && instr_count === 8'd3) else begin
            n_fail++;
            $error("FAIL prog_end: observed halted=%b cnt=%0d, expected halted=1 cnt=3",
                   halted, instr_count);
        end

        // HALT is deaf to run and step.
        cnt_snap = instr_count;
        for (int i = 0; i < 20; i++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), "halt_hold");
        n_checks++;
        assert (instr_count === cnt_snap && tstate === 3'd7) else begin
            n_fail++;
            $error("FAIL halt_stable: observed t=%0d cnt=%0d, expected t=7 cnt=%0d",
                   tstate, instr_count, cnt_snap);
        end

        // Reset out of HALT, then OUT, an undefined opcode, and run+step overlap.
        pulse_reset("rst_from_halt");
        for (int t = 0; t < 6; t++) tick(1'b1, 1'b0, 4'hE, "op_out");
        for (int t = 0; t < 6; t++) tick(1'b1, 1'b0, 4'h7, "op_nop7");
        for (int t = 0; t < 6; t++) tick(1'b1, 1'(t % 2 == 0), 4'h7, "run_and_step");
        for (int t = 0; t < 12; t++) tick(1'b0, 1'(t % 2 == 0), 4'h1, "step_add");
        tick(1'b0, 1'b0, 4'h1, "after_step_add");

        // Abandon an ADD in T5.
        for (int t = 0; t < 4; t++) tick(1'b1, 1'b0, 4'h1, "add_pre_rst");
        pulse_reset("rst_mid_t5");
        tick(1'b1, 1'b0, 4'h1, "post_rst_t1");

        // Saturation of the instruction counter.
        pulse_reset("rst_before_sat");
        for (int i = 0; i < 300; i++)
            for (int t = 0; t < 6; t++) tick(1'b1, 1'b0, 4'h9, "nop_sat");
        tick(1'b0, 1'b0, 4'h9, "sat_idle");
        n_checks++;
        assert (instr_count === 8'hFF) else begin
            n_fail++;
            $error("FAIL count_saturate: observed cnt=%02h, expected ff", instr_count);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
